// File: rtl/fpu_mul_sequencer_pkg.sv
// Shared definitions for the FP multiply front end: sequencer states,
// per-format quiet-NaN encodings and the default status-flag width.
package fpu_mul_sequencer_pkg;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_START,
        SEQ_BUSY,
        SEQ_RESP,
        SEQ_RECYCLE
    } fpuSeqState_t;

    localparam logic [15:0] QNAN_FP16 = 16'h7E00;
    localparam logic [31:0] QNAN_FP32 = 32'h7FC0_0000;

    localparam int DEFAULT_FLAGW = 5;

endpackage

// File: rtl/fpu_seq_watchdog.sv
// Busy-cycle watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the count would reach TIMEOUT.
module fpu_seq_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] count;
    logic [CW-1:0] countNext;

    assign countNext = count + 1'b1;

    // Expiry is reported during the TIMEOUT-th enabled cycle so the caller can
    // retire on that same edge instead of one cycle later.
    assign expired = enable && (countNext == LIMIT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= countNext;
        end
    end

endmodule

// File: rtl/fpu_mul_sequencer.sv
// Issue/retire front end for the FP multiply unit: one command in flight,
// start pulse, done or watchdog retire, response register and unit recycle.
module fpu_mul_sequencer
    import fpu_mul_sequencer_pkg::*;
#(
    parameter int FPW     = 16,
    parameter int FLAGW   = DEFAULT_FLAGW,
    parameter int TAGW    = 4,
    parameter int TIMEOUT = 64,
    parameter logic [FPW-1:0] QNAN = FPW'(QNAN_FP16)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmdValid,
    output logic             cmdReady,
    input  logic [FPW-1:0]   cmdOpA,
    input  logic [FPW-1:0]   cmdOpB,
    input  logic [TAGW-1:0]  cmdTag,
    output logic [FPW-1:0]   unitIn1,
    output logic [FPW-1:0]   unitIn2,
    output logic             unitStart,
    output logic             unitReset,
    input  logic [FPW-1:0]   unitOut,
    input  logic             unitDone,
    input  logic [3:0]       unitCond,
    input  logic [FLAGW-1:0] unitFlags,
    output logic             rspValid,
    input  logic             rspReady,
    output logic [FPW-1:0]   rspResult,
    output logic [3:0]       rspCond,
    output logic [FLAGW-1:0] rspFlags,
    output logic [TAGW-1:0]  rspTag,
    output logic             rspTimeout,
    output logic [FLAGW-1:0] accFlags,
    input  logic             accClear
);
    fpuSeqState_t state;
    fpuSeqState_t stateNext;

    logic            wdExpired;
    logic            captureDone;
    logic            captureTimeout;
    logic            cmdAccept;
    logic            rspHandshake;
    logic [TAGW-1:0] tagReg;

    assign unitStart    = (state == SEQ_START);
    assign rspValid     = (state == SEQ_RESP);
    assign rspTag       = tagReg;
    assign cmdAccept    = cmdReady && cmdValid;
    assign rspHandshake = rspValid && rspReady;

    fpu_seq_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) watchdog (
        .clock  (clock),
        .reset  (reset),
        .clear  (state == SEQ_START),
        .enable (state == SEQ_BUSY),
        .expired(wdExpired)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= SEQ_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // A done level coinciding with watchdog expiry is treated as a normal
    // completion; done is only looked at in BUSY.
    always_comb begin
        stateNext      = state;
        captureDone    = 1'b0;
        captureTimeout = 1'b0;
        case (state)
            SEQ_IDLE: begin
                if (cmdAccept) begin
                    stateNext = SEQ_START;
                end
            end
            SEQ_START: begin
                stateNext = SEQ_BUSY;
            end
            SEQ_BUSY: begin
                if (unitDone) begin
                    stateNext   = SEQ_RESP;
                    captureDone = 1'b1;
                end else if (wdExpired) begin
                    stateNext      = SEQ_RESP;
                    captureTimeout = 1'b1;
                end
            end
            SEQ_RESP: begin
                if (rspReady) begin
                    stateNext = SEQ_RECYCLE;
                end
            end
            SEQ_RECYCLE: begin
                stateNext = SEQ_IDLE;
            end
            default: begin
                stateNext = SEQ_IDLE;
            end
        endcase
    end

    // Registered from the next state, so cmdReady stays low until the first
    // clock after reset release and unitReset covers exactly the RECYCLE cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            unitReset <= 1'b1;
            cmdReady  <= 1'b0;
        end else begin
            unitReset <= (stateNext == SEQ_RECYCLE);
            cmdReady  <= (stateNext == SEQ_IDLE);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            unitIn1 <= '0;
            unitIn2 <= '0;
            tagReg  <= '0;
        end else if (cmdAccept) begin
            unitIn1 <= cmdOpA;
            unitIn2 <= cmdOpB;
            tagReg  <= cmdTag;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rspResult  <= '0;
            rspCond    <= '0;
            rspFlags   <= '0;
            rspTimeout <= 1'b0;
        end else if (captureDone) begin
            rspResult  <= unitOut;
            rspCond    <= unitCond;
            rspFlags   <= unitFlags;
            rspTimeout <= 1'b0;
        end else if (captureTimeout) begin
            rspResult  <= QNAN;
            rspCond    <= '0;
            rspFlags   <= '0;
            rspTimeout <= 1'b1;
        end
    end

    // Clear takes effect before the OR of a coincident retirement.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            accFlags <= '0;
        end else if (accClear) begin
            accFlags <= rspHandshake ? rspFlags : '0;
        end else if (rspHandshake) begin
            accFlags <= accFlags | rspFlags;
        end
    end

endmodule

// File: tb/tb_fpu_mul_sequencer.sv
// Self-checking bench for fpu_mul_sequencer with a behavioural multiply-unit
// model whose done latency is set per operation.
`timescale 1ns/1ps
module tb_fpu_mul_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmdValid = 1'b0;
    logic        cmdReady;
    logic [15:0] cmdOpA = '0;
    logic [15:0] cmdOpB = '0;
    logic [3:0]  cmdTag = '0;
    logic [15:0] unitIn1;
    logic [15:0] unitIn2;
    logic        unitStart;
    logic        unitReset;
    logic [15:0] unitOut = '0;
    logic        unitDone = 1'b0;
    logic [3:0]  unitCond = '0;
    logic [4:0]  unitFlags = '0;
    logic        rspValid;
    logic        rspReady = 1'b0;
    logic [15:0] rspResult;
    logic [3:0]  rspCond;
    logic [4:0]  rspFlags;
    logic [3:0]  rspTag;
    logic        rspTimeout;
    logic [4:0]  accFlags;
    logic        accClear = 1'b0;

    int total = 0;
    int bad = 0;

    int   doneDelay = 0;
    logic glitchDone = 1'b0;
    int   busyCnt = 0;
    logic running = 1'b0;
    int   startPulses = 0;
    int   resetPulses = 0;

    fpu_mul_sequencer #(
        .FPW(16), .FLAGW(5), .TAGW(4), .TIMEOUT(64), .QNAN(16'h7E00)
    ) dut (
        .clock(clock), .reset(reset),
        .cmdValid(cmdValid), .cmdReady(cmdReady),
        .cmdOpA(cmdOpA), .cmdOpB(cmdOpB), .cmdTag(cmdTag),
        .unitIn1(unitIn1), .unitIn2(unitIn2),
        .unitStart(unitStart), .unitReset(unitReset),
        .unitOut(unitOut), .unitDone(unitDone),
        .unitCond(unitCond), .unitFlags(unitFlags),
        .rspValid(rspValid), .rspReady(rspReady),
        .rspResult(rspResult), .rspCond(rspCond), .rspFlags(rspFlags),
        .rspTag(rspTag), .rspTimeout(rspTimeout),
        .accFlags(accFlags), .accClear(accClear)
    );

    always #5 clock = ~clock;

    // Unit model: done rises in the doneDelay-th cycle after START and holds
    // until the local reset; doneDelay of 0 means the unit hangs.
    always @(negedge clock) begin
        if (unitReset) begin
            running  = 1'b0;
            busyCnt  = 0;
            unitDone = 1'b0;
        end else if (unitStart) begin
            running  = 1'b1;
            busyCnt  = 0;
            unitDone = glitchDone;
        end else if (running) begin
            busyCnt  = busyCnt + 1;
            unitDone = (doneDelay != 0) && (busyCnt >= doneDelay);
        end
    end

    always @(posedge clock) begin
        if (!reset) begin
            startPulses <= startPulses + (unitStart ? 1 : 0);
            resetPulses <= resetPulses + (unitReset ? 1 : 0);
        end
    end

    typedef struct {
        logic [15:0] opA;
        logic [15:0] opB;
        logic [3:0]  tag;
        logic [15:0] out;
        logic [3:0]  cond;
        logic [4:0]  flags;
        int          delay;
        logic [15:0] expResult;
        logic [3:0]  expCond;
        logic [4:0]  expFlags;
        logic        expTimeout;
        int          expLatency;
        logic [4:0]  expAcc;
    } vec_t;

    vec_t vecs[5];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Presents a command from an IDLE-aligned negedge and returns at the START negedge.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic [3:0] t,
                                 input logic [15:0] o, input logic [3:0] c, input logic [4:0] f,
                                 input int d);
        int n;
        unitOut   = o;
        unitCond  = c;
        unitFlags = f;
        doneDelay = d;
        cmdOpA    = a;
        cmdOpB    = b;
        cmdTag    = t;
        cmdValid  = 1'b1;
        n = 0;
        while (!cmdReady && n < 100) begin
            @(negedge clock);
            n++;
        end
        checkOutput("cmdReadyBeforeAccept", cmdReady, 1);
        @(negedge clock);
        cmdValid = 1'b0;
        checkOutput("unitStartAfterAccept", unitStart, 1);
        checkOutput("unitIn1", unitIn1, a);
        checkOutput("unitIn2", unitIn2, b);
    endtask

    task automatic waitResp(output int lat);
        lat = 0;
        while (!rspValid && lat < 200) begin
            @(negedge clock);
            lat++;
        end
        if (!rspValid) begin
            total = total + 1;
            bad = bad + 1;
            $display("[TB] FAIL rspWait: got no rspValid within %0d cycles", lat);
        end
    endtask

    task automatic retire(input logic clr);
        rspReady = 1'b1;
        accClear = clr;
        @(negedge clock);
        rspReady = 1'b0;
        accClear = 1'b0;
        checkOutput("recycleUnitReset", unitReset, 1);
        checkOutput("recycleRspValid", rspValid, 0);
        checkOutput("recycleCmdReady", cmdReady, 0);
        @(negedge clock);
        checkOutput("idleUnitReset", unitReset, 0);
        checkOutput("idleCmdReady", cmdReady, 1);
    endtask

    initial begin
        int lat;
        int s0;
        int r0;
        logic ok;
        logic sawRsp;
        int issued;
        int got;
        int cyc;
        logic [3:0] tagList[3];
        logic [3:0] gotTags[3];
        int acceptCyc[3];

        vecs[0] = '{16'h3C00, 16'h4000, 4'd3,  16'h4000, 4'b0000, 5'b00000, 12,
                    16'h4000, 4'b0000, 5'b00000, 1'b0, 13, 5'b00000};
        vecs[1] = '{16'h4000, 16'h4100, 4'd5,  16'h4500, 4'b0000, 5'b00001, 3,
                    16'h4500, 4'b0000, 5'b00001, 1'b0, 4,  5'b00001};
        vecs[2] = '{16'h0000, 16'h3C00, 4'd6,  16'h0000, 4'b1000, 5'b00100, 1,
                    16'h0000, 4'b1000, 5'b00100, 1'b0, 2,  5'b00101};
        vecs[3] = '{16'h7C00, 16'h0000, 4'd9,  16'h1234, 4'b1111, 5'b11111, 0,
                    16'h7E00, 4'b0000, 5'b00000, 1'b1, 65, 5'b00101};
        vecs[4] = '{16'h3800, 16'h3800, 4'd10, 16'h3400, 4'b0010, 5'b00000, 64,
                    16'h3400, 4'b0010, 5'b00000, 1'b0, 65, 5'b00101};

        @(negedge clock);
        checkOutput("resetUnitReset", unitReset, 1);
        checkOutput("resetCmdReady", cmdReady, 0);
        checkOutput("resetRspValid", rspValid, 0);
        checkOutput("resetUnitStart", unitStart, 0);
        checkOutput("resetUnitIn1", unitIn1, 0);
        checkOutput("resetAccFlags", accFlags, 0);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("releaseUnitReset", unitReset, 0);
        checkOutput("releaseCmdReady", cmdReady, 1);

        for (int i = 0; i < 5; i++) begin
            s0 = startPulses;
            r0 = resetPulses;
            applyStimulus(vecs[i].opA, vecs[i].opB, vecs[i].tag, vecs[i].out,
                          vecs[i].cond, vecs[i].flags, vecs[i].delay);
            waitResp(lat);
            checkOutput($sformatf("v%0d latency", i), lat, vecs[i].expLatency);
            checkOutput($sformatf("v%0d rspResult", i), rspResult, vecs[i].expResult);
            checkOutput($sformatf("v%0d rspCond", i), rspCond, vecs[i].expCond);
            checkOutput($sformatf("v%0d rspFlags", i), rspFlags, vecs[i].expFlags);
            checkOutput($sformatf("v%0d rspTag", i), rspTag, vecs[i].tag);
            checkOutput($sformatf("v%0d rspTimeout", i), rspTimeout, vecs[i].expTimeout);
            retire(1'b0);
            checkOutput($sformatf("v%0d accFlags", i), accFlags, vecs[i].expAcc);
            checkOutput($sformatf("v%0d startPulses", i), startPulses - s0, 1);
            checkOutput($sformatf("v%0d resetPulses", i), resetPulses - r0, 1);
        end

        // accClear coincident with a handshake keeps only the new flags.
        applyStimulus(16'h4200, 16'h4200, 4'd11, 16'h4880, 4'b0000, 5'b10000, 2);
        waitResp(lat);
        retire(1'b1);
        checkOutput("clearWithHandshake", accFlags, 5'b10000);

        // Backpressure: response and operands hold, new command is refused.
        s0 = startPulses;
        applyStimulus(16'h4400, 16'h3C00, 4'd7, 16'h4400, 4'b0000, 5'b00000, 4);
        waitResp(lat);
        cmdValid = 1'b1;
        cmdOpA   = 16'hFFFF;
        cmdOpB   = 16'hFFFF;
        cmdTag   = 4'hE;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            ok = rspValid && (rspResult == 16'h4400) && (rspTag == 4'd7) &&
                 (rspCond == 4'b0000) && (rspFlags == 5'b00000) && !rspTimeout &&
                 (unitIn1 == 16'h4400) && (unitIn2 == 16'h3C00) && !cmdReady;
            checkOutput($sformatf("holdCycle%0d", k), ok, 1);
        end
        cmdValid = 1'b0;
        retire(1'b0);
        checkOutput("backpressureStarts", startPulses - s0, 1);
        checkOutput("backpressureAcc", accFlags, 5'b10000);

        // Back-to-back with done glitching high during START.
        tagList[0] = 4'hA;
        tagList[1] = 4'hB;
        tagList[2] = 4'hC;
        glitchDone = 1'b1;
        doneDelay  = 2;
        unitOut    = 16'h3C00;
        unitCond   = 4'b0000;
        unitFlags  = 5'b00000;
        rspReady   = 1'b1;
        s0 = startPulses;
        r0 = resetPulses;
        issued = 0;
        got = 0;
        cyc = 0;
        cmdValid = 1'b1;
        while (got < 3 && cyc < 200) begin
            if (rspValid) begin
                gotTags[got] = rspTag;
                got++;
            end
            if (issued == 3 && unitStart) cmdValid = 1'b0;
            if (cmdReady && issued < 3) begin
                cmdTag = tagList[issued];
                cmdOpA = {12'h3C0, tagList[issued]};
                acceptCyc[issued] = cyc;
                issued++;
            end
            @(negedge clock);
            cyc++;
        end
        rspReady = 1'b0;
        cmdValid = 1'b0;
        glitchDone = 1'b0;
        checkOutput("b2bResponses", got, 3);
        @(negedge clock);
        @(negedge clock);
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("b2bTag%0d", k), (got > k) ? gotTags[k] : 4'h0, tagList[k]);
        end
        checkOutput("b2bSpacing", acceptCyc[1] - acceptCyc[0], 6);
        checkOutput("b2bStarts", startPulses - s0, 3);
        checkOutput("b2bResets", resetPulses - r0, 3);

        // Mid-operation reset with a hung unit.
        applyStimulus(16'h5000, 16'h5000, 4'd4, 16'h0000, 4'b0000, 5'b00000, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        checkOutput("midResetUnitReset", unitReset, 1);
        checkOutput("midResetCmdReady", cmdReady, 0);
        checkOutput("midResetUnitIn1", unitIn1, 0);
        checkOutput("midResetAccFlags", accFlags, 0);
        checkOutput("midResetRspTag", rspTag, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        sawRsp = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            if (rspValid) sawRsp = 1'b1;
        end
        checkOutput("noRspAfterReset", sawRsp, 0);
        checkOutput("postResetUnitReset", unitReset, 0);
        applyStimulus(16'h3C00, 16'h3C00, 4'd2, 16'h3C00, 4'b0000, 5'b00010, 5);
        waitResp(lat);
        checkOutput("postResetLatency", lat, 6);
        checkOutput("postResetResult", rspResult, 16'h3C00);
        checkOutput("postResetTag", rspTag, 4'd2);
        retire(1'b0);
        checkOutput("postResetAcc", accFlags, 5'b00010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fpu_mul_sequencer.md
Name: fpu_mul_sequencer

Overview:
- Issue/retire front end for the floating-point multiply coprocessor.
- Accepts operand commands over a valid/ready interface and holds the operands stable on the unit's inputs.
- Drives a one-cycle start, waits for done, then captures the result, condition codes and status flags into a response register.
- The unit's control FSM parks in its done state until reset, so the sequencer recycles it with a one-cycle local reset after every operation. It also guards against a hung unit with a watchdog and accumulates sticky status flags.

Parameters:
FPW, 16, operand/result width (fp16 default)
FLAGW, 5, width of the unit's status-flag vector
TAGW, 4, command tag width, returned unchanged
TIMEOUT, 64, maximum BUSY cycles before forced retire
QNAN, 16'h7E00, result value driven on timeout

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high
cmdValid  in  1  command present
cmdReady  out  1  sequencer can accept a command
cmdOpA  in  FPW  operand 1
cmdOpB  in  FPW  operand 2
cmdTag  in  TAGW  command tag
unitIn1  out  FPW  operand 1 to the unit, registered
unitIn2  out  FPW  operand 2 to the unit, registered
unitStart  out  1  start pulse to the unit
unitReset  out  1  local reset to the unit, registered
unitOut  in  FPW  unit result
unitDone  in  1  unit done level
unitCond  in  4  unit condition codes {Z,C,N,V}
unitFlags  in  FLAGW  unit status flags
rspValid  out  1  response present
rspReady  in  1  consumer accepts the response
rspResult  out  FPW  captured result
rspCond  out  4  captured condition codes
rspFlags  out  FLAGW  captured status flags
rspTag  out  TAGW  tag of the retired command
rspTimeout  out  1  response was produced by the watchdog
accFlags  out  FLAGW  sticky OR of retired flags
accClear  in  1  synchronous clear of accFlags

Behaviour:
- Reset:
  - State is IDLE.
  - unitReset=1, so the unit is held in reset while the sequencer is in reset.
  - All other outputs are 0, including unitIn1/2, rsp* and accFlags.
  - Reset is honoured in any state. An in-flight operation is discarded and no response is produced.
- States: IDLE, START, BUSY, RESP, RECYCLE. All outputs are registered or decoded from state only.
- IDLE:
  - cmdReady=1. unitReset falls to 0 on the first clock after reset release.
  - On cmdValid&cmdReady: latch cmdOpA/B into unitIn1/2, latch cmdTag, go to START.
- START:
  - unitStart=1 for exactly this one cycle.
  - Clear the watchdog counter. Go to BUSY.
  - unitDone is ignored in this state.
- BUSY:
  - Increment the watchdog counter each cycle.
  - On the first cycle unitDone=1: capture unitOut, unitCond and unitFlags into rsp*, set rspTimeout=0, go to RESP.
  - If the count reaches TIMEOUT with unitDone=0: set rspResult=QNAN, rspCond=0, rspFlags=0, rspTimeout=1, go to RESP.
  - If done and the timeout occur in the same cycle, done wins.
- RESP:
  - rspValid=1. All rsp* fields are held stable until the handshake.
  - unitIn1/2 are held unchanged from START through RESP.
  - On rspValid&rspReady: accFlags |= rspFlags, go to RECYCLE.
- RECYCLE:
  - unitReset=1 for exactly one cycle, then go to IDLE.
  - cmdReady=0.
- Latency and throughput:
  - A command accepted at edge k gives unitStart high in cycle k+1.
  - rspValid rises the cycle after unitDone is first sampled in BUSY.
  - With rspReady held at 1, the minimum command-to-command spacing is unit latency + 4 cycles.
- accClear:
  - Clears accFlags.
  - If it coincides with a response handshake, accFlags = rspFlags (clear first, then OR).
- Only one command is in flight. cmdReady is 0 in every state except IDLE.

Decomposition:
- Shared FPU package:
  - fpuSeqState_t enum {SEQ_IDLE, SEQ_START, SEQ_BUSY, SEQ_RESP, SEQ_RECYCLE}.
  - Per-format quiet-NaN constants (fp16 7E00, fp32 7FC00000).
  - Default flag width.
- One sub-module, fpu_seq_watchdog:
  - Parameterised counter with clear and enable inputs and an expired output.
  - Counter width is $clog2(TIMEOUT+1).

Test Plan:
1. Basic multiply: cmd 3C00×4000, tag 3, unit model done after 12 cycles with result 4000 and flags 0. Required: unitStart high exactly 1 cycle; rspValid one cycle after done; rspResult=4000, rspTag=3, rspTimeout=0; unitReset pulses exactly 1 cycle after the handshake.
2. Backpressure: rspReady held low 5 cycles in RESP. Required: rspValid stays 1, all rsp* fields and unitIn1/2 unchanged, cmdReady=0, and a pending cmdValid is not accepted.
3. Watchdog: unit model never asserts done. Required: after TIMEOUT=64 BUSY cycles, rspValid=1, rspResult=7E00, rspTimeout=1, rspFlags=0. Also, done arriving in the exact expiry cycle produces a normal response with rspTimeout=0.
4. Flag accumulation: two ops retiring with flags 00001 then 00100 gives accFlags=00101. accClear asserted coincident with a third handshake carrying flags 10000 gives accFlags=10000.
5. Back-to-back commands: cmdValid held high for 3 commands, rspReady=1. Required: 3 responses in order with the correct tags; exactly one unitStart and one unitReset pulse per command; unitDone sampled high in START is ignored.
6. Mid-operation reset: assert reset during BUSY. Required: outputs return to reset values asynchronously with unitReset=1, no response is produced, and the next command after release completes normally.
